// File: rtl/npc_dmem_resp.sv
// ============================================================================
// Module   : npc_dmem_resp
// Brief    : Data-memory responder for the single-cycle core. It has a word
//            array with a fixed access latency and stalls the core through
//            mem_hold. The optional NPC_DMEM_ERR_EN build adds range checking
//            and a sticky mem_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_dmem_resp #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 64,
    parameter int                DEPTH_LOG2  = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_raddr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
`ifdef NPC_DMEM_ERR_EN
    output logic              mem_err,
`endif
    output logic              mem_hold
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_array [DEPTH];
    logic [ADDR_W-1:0]   off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                in_range;
    logic                complete;
    logic                wr_en;

    assign off      = addr_q - BASE_ADDR;
    assign idx      = off[DEPTH_LOG2+2:3];
    assign complete = (state_q == ST_WAIT) && (cnt_q == 4'd0);

`ifdef NPC_DMEM_ERR_EN
    assign in_range = (addr_q >= BASE_ADDR) && (off[ADDR_W-1:DEPTH_LOG2+3] == '0);
    assign mem_err  = err_q;

    logic unused_bits;
    assign unused_bits = ^off[2:0];
`else
    // Without range checking the index simply wraps modulo the array depth.
    assign in_range = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{off[2:0], off[ADDR_W-1:DEPTH_LOG2+3], err_q};
`endif

    assign wr_en     = complete && we_q && in_range;
    assign mem_rdata = rdata_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_hold = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_hold = mem_ce && rst_n;
                if (mem_ce) begin
                    we_d    = mem_we;
                    addr_d  = mem_we ? mem_waddr : mem_raddr;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_hold = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = in_range ? mem_array[idx] : '0;
                    end
`ifdef NPC_DMEM_ERR_EN
                    err_d = err_q | ~in_range;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; an aborted write never reaches wr_en.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[idx] <= wdata_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_npc_dmem_resp.sv
// Directed testbench for npc_dmem_resp (WAIT_CYCLES=2, DEPTH_LOG2=10).
`default_nettype none

module tb_npc_dmem_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_raddr = '0;
    logic [63:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;
    logic [63:0] mem_rdata;
    logic        mem_hold;
    logic        mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    npc_dmem_resp #(
        .DATA_W     (64),
        .ADDR_W     (64),
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (64'h8000_0000),
        .WAIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_ce   (mem_ce),
        .mem_we   (mem_we),
        .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef NPC_DMEM_ERR_EN
        .mem_err  (mem_err),
`endif
        .mem_hold (mem_hold)
    );

`ifndef NPC_DMEM_ERR_EN
    assign mem_err = 1'b0;
`endif

    // One full access starting just after a rising edge; returns the number of
    // hold cycles and the read data seen in the first non-hold cycle.
    task automatic access(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                          output int hc, output logic [63:0] rd);
        mem_ce    = 1'b1;
        mem_we    = we;
        mem_raddr = we ? (addr ^ 64'h8) : addr;
        mem_waddr = we ? addr : (addr ^ 64'h8);
        mem_wdata = wd;
        hc = 0;
        rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_hold) begin
                hc++;
            end else begin
                rd = mem_rdata;
                break;
            end
        end
        mem_ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (mem_hold !== 1'b0) $display("FAIL reset_hold: got %b want 0", mem_hold);
        else n_pass++;
        n_checks++;
        if (mem_rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", mem_rdata);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", mem_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int hc;
        logic [63:0] rd;
        access(1'b1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, hc, rd);
        n_checks++;
        if (hc !== 3) $display("FAIL wr_hold_cycles: got %0d want 3", hc);
        else n_pass++;
        access(1'b0, 64'h8000_0010, 64'h0, hc, rd);
        n_checks++;
        if (hc !== 3) $display("FAIL rd_hold_cycles: got %0d want 3", hc);
        else n_pass++;
        n_checks++;
        if (rd !== 64'hDEAD_BEEF_0123_4567) $display("FAIL rd_data: got %h want deadbeef01234567", rd);
        else n_pass++;
    endtask

    task automatic test_low_bits();
        int hc;
        logic [63:0] rd;
        access(1'b1, 64'h8000_0008, 64'h1111, hc, rd);
        access(1'b0, 64'h8000_000F, 64'h0, hc, rd);
        n_checks++;
        if (rd !== 64'h1111) $display("FAIL low_bits: got %h want 1111", rd);
        else n_pass++;
    endtask

    task automatic test_wait_change();
        int hc;
        logic [63:0] rd;
        access(1'b1, 64'h8000_0000, 64'hA, hc, rd);
        access(1'b1, 64'h8000_0008, 64'hB, hc, rd);
        mem_ce    = 1'b1;
        mem_we    = 1'b0;
        mem_raddr = 64'h8000_0000;
        mem_waddr = 64'h8000_0008;
        @(posedge clk);
        #1;
        mem_raddr = 64'h8000_0008;
        rd = 'x;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_hold) begin
                rd = mem_rdata;
                break;
            end
        end
        mem_ce = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rd !== 64'hA) $display("FAIL wait_change: got %h want a", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hc;
        logic [63:0] rd;
        access(1'b1, 64'h8000_0020, 64'h1234, hc, rd);
        access(1'b0, 64'h8000_0010, 64'h0, hc, rd);
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = 64'h8000_0020;
        mem_raddr = 64'h8000_0028;
        mem_wdata = 64'h55;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (mem_hold !== 1'b1) $display("FAIL midrst_pre_hold: got %b want 1", mem_hold);
        else n_pass++;
        #1;
        rst_n  = 1'b0;
        mem_ce = 1'b0;
        #1;
        n_checks++;
        if (mem_hold !== 1'b0) $display("FAIL midrst_hold: got %b want 0", mem_hold);
        else n_pass++;
        n_checks++;
        if (mem_rdata !== 64'h0) $display("FAIL midrst_rdata: got %h want 0", mem_rdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 64'h8000_0020, 64'h0, hc, rd);
        n_checks++;
        if (rd !== 64'h1234) $display("FAIL midrst_no_commit: got %h want 1234", rd);
        else n_pass++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            mem_raddr = 64'h8000_0000 + 64'(i * 8);
            @(negedge clk);
            n_checks++;
            if (mem_hold !== 1'b0) $display("FAIL idle_hold[%0d]: got %b want 0", i, mem_hold);
            else n_pass++;
            n_checks++;
            if (mem_rdata !== 64'h1234) $display("FAIL idle_rdata[%0d]: got %h want 1234", i, mem_rdata);
            else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_hold;
        exp_hold  = 8'b0111_0111;
        mem_ce    = 1'b1;
        mem_we    = 1'b0;
        mem_raddr = 64'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_hold !== exp_hold[i]) $display("FAIL b2b_hold[%0d]: got %b want %b", i, mem_hold, exp_hold[i]);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (mem_rdata !== 64'hA) $display("FAIL b2b_rd0: got %h want a", mem_rdata);
                else n_pass++;
                mem_raddr = 64'h8000_0010;
            end
            if (i == 7) begin
                n_checks++;
                if (mem_rdata !== 64'hDEAD_BEEF_0123_4567) $display("FAIL b2b_rd1: got %h want deadbeef01234567", mem_rdata);
                else n_pass++;
            end
        end
        mem_ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_range();
        int hc;
        logic [63:0] rd;
`ifdef NPC_DMEM_ERR_EN
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL err_before: got %b want 0", mem_err);
        else n_pass++;
        access(1'b0, 64'h9000_0000, 64'h0, hc, rd);
        n_checks++;
        if (hc !== 3) $display("FAIL oor_hold_cycles: got %0d want 3", hc);
        else n_pass++;
        n_checks++;
        if (rd !== 64'h0) $display("FAIL oor_rdata: got %h want 0", rd);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b1) $display("FAIL oor_err: got %b want 1", mem_err);
        else n_pass++;
        access(1'b1, 64'h8000_2000, 64'h77, hc, rd);
        access(1'b0, 64'h8000_0000, 64'h0, hc, rd);
        n_checks++;
        if (rd !== 64'hA) $display("FAIL oor_write_dropped: got %h want a", rd);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", mem_err);
        else n_pass++;
`else
        access(1'b1, 64'h8000_2000, 64'h77, hc, rd);
        access(1'b0, 64'h8000_0000, 64'h0, hc, rd);
        n_checks++;
        if (rd !== 64'h77) $display("FAIL wrap_rdata: got %h want 77", rd);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_low_bits();
        test_wait_change();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        test_range();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
